// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU dispatch path.
//   - fpu_state_e  : dispatcher FSM states
//   - FU_*         : unit index assignment of the attached AXI-Stream cores
//   - FpuDataWDefault : default operand/result width
package fpu_pkg;

  localparam int unsigned FpuDataWDefault = 32;

  // Unit indices as wired at the top level; fsqrt/ftoi/itof will follow.
  localparam int unsigned FU_FADD = 0;
  localparam int unsigned FU_FSUB = 1;
  localparam int unsigned FU_FMUL = 2;
  localparam int unsigned FU_FDIV = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StResp
  } fpu_state_e;

endpackage

// File: rtl/fpu_watchdog.sv
// Loadable down-counter used as an operation watchdog.
//   clk, rstn   : clock, synchronous active-low reset
//   clear       : force the count to zero (highest priority after reset)
//   load        : load load_value
//   load_value  : value loaded on load
//   enable      : count down by one per cycle, saturating at zero
//   expired     : enable is high and the count has reached zero
module fpu_watchdog #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == '0);

endmodule

// File: rtl/fpu_axis_dispatch.sv
// Dispatcher between the CPU execute stage and NUM_UNITS AXI4-Stream FP cores.
//   clk, rstn            : clock, synchronous active-low reset
//   req_*                : CPU request (valid/ready, unit select, operands a/b)
//   rsp_*                : CPU response (valid/ready, data, err)
//   busy                 : an operation is in progress or a response is pending
//   unit_a_* / unit_b_*  : per-unit operand streams, unit i at [i*DATA_W +: DATA_W]
//   unit_r_*             : per-unit result streams, same layout
// Operands are broadcast on every slice; only tvalid/tready are steered to the
// selected unit. A watchdog converts a hung core into an error response.
module fpu_axis_dispatch
  import fpu_pkg::*;
#(
  parameter int unsigned DATA_W         = FpuDataWDefault,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned UNIT_W         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [UNIT_W-1:0]           req_unit,
  input  logic [DATA_W-1:0]           req_a,
  input  logic [DATA_W-1:0]           req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [NUM_UNITS*DATA_W-1:0] unit_a_tdata,
  output logic [NUM_UNITS-1:0]        unit_a_tvalid,
  input  logic [NUM_UNITS-1:0]        unit_a_tready,
  output logic [NUM_UNITS*DATA_W-1:0] unit_b_tdata,
  output logic [NUM_UNITS-1:0]        unit_b_tvalid,
  input  logic [NUM_UNITS-1:0]        unit_b_tready,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_r_tdata,
  input  logic [NUM_UNITS-1:0]        unit_r_tvalid,
  output logic [NUM_UNITS-1:0]        unit_r_tready
);

  // Watchdog counts TIMEOUT_CYCLES-1 down to zero from operand issue.
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLoad =
      (TIMEOUT_CYCLES == 0) ? '0 : TimerW'(TIMEOUT_CYCLES - 1);
  localparam bit WdOn = (TIMEOUT_CYCLES != 0);

  fpu_state_e          state_q, state_d;
  logic [UNIT_W-1:0]   unit_q, unit_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                a_done_q, a_done_d;
  logic                b_done_q, b_done_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_UNITS-1:0] sel;
  logic                 a_rdy, b_rdy, r_vld;
  logic [DATA_W-1:0]    r_data;
  logic                 req_legal;
  logic                 wd_load, wd_en, wd_clear, wd_expired, timeout;

  // One-hot decode of the latched unit; an illegal index never reaches SEND.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      sel[i] = (unit_q == UNIT_W'(i));
    end
  end

  always_comb begin
    r_data = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (sel[i]) begin
        r_data = unit_r_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign a_rdy     = |(unit_a_tready & sel);
  assign b_rdy     = |(unit_b_tready & sel);
  assign r_vld     = |(unit_r_tvalid & sel);
  assign req_legal = (32'(req_unit) < NUM_UNITS);

  assign wd_load  = (state_q == StIdle) && req_valid;
  assign wd_en    = (state_q == StSend) || (state_q == StWait);
  assign wd_clear = (state_q == StResp);
  assign timeout  = WdOn && wd_expired;

  fpu_watchdog #(
    .WIDTH (TimerW)
  ) u_watchdog (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (wd_clear),
    .load       (wd_load),
    .load_value (TimerLoad),
    .enable     (wd_en),
    .expired    (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    a_done_d   = a_done_q;
    b_done_d   = b_done_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          unit_d   = req_unit;
          opa_d    = req_a;
          opb_d    = req_b;
          a_done_d = 1'b0;
          b_done_d = 1'b0;
          if (req_legal) begin
            state_d = StSend;
          end else begin
            state_d    = StResp;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        end
      end
      StSend: begin
        // tvalid is high exactly while the channel is not yet done.
        a_done_d = a_done_q || a_rdy;
        b_done_d = b_done_q || b_rdy;
        if (a_done_d && b_done_d) begin
          state_d = StWait;
        end else if (timeout) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      StWait: begin
        if (r_vld) begin
          state_d    = StResp;
          rsp_data_d = r_data;
          rsp_err_d  = 1'b0;
        end else if (timeout) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      unit_q     <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  assign unit_a_tdata  = {NUM_UNITS{opa_q}};
  assign unit_b_tdata  = {NUM_UNITS{opb_q}};
  assign unit_a_tvalid = ((state_q == StSend) && !a_done_q) ? sel : '0;
  assign unit_b_tvalid = ((state_q == StSend) && !b_done_q) ? sel : '0;
  assign unit_r_tready = (state_q == StWait) ? sel : '0;

endmodule

// File: tb/tb_fpu_axis_dispatch.sv
module tb_fpu_axis_dispatch;

  localparam int NU = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Main DUT: four units, 16-cycle watchdog.
  logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]       req_unit;
  logic [DW-1:0]    req_a, req_b, rsp_data;
  logic [NU*DW-1:0] unit_a_tdata, unit_b_tdata, unit_r_tdata;
  logic [NU-1:0]    unit_a_tvalid, unit_a_tready, unit_b_tvalid, unit_b_tready;
  logic [NU-1:0]    unit_r_tvalid, unit_r_tready;

  // Second DUT: three units, so unit index 3 is illegal.
  logic             req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3, busy3;
  logic [DW-1:0]    rsp_data3;
  logic [3*DW-1:0]  a_tdata3, b_tdata3;
  logic [2:0]       a_tvalid3, b_tvalid3, r_tready3;

  fpu_axis_dispatch #(
    .DATA_W(DW), .NUM_UNITS(NU), .UNIT_W(2), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .unit_a_tdata(unit_a_tdata), .unit_a_tvalid(unit_a_tvalid), .unit_a_tready(unit_a_tready),
    .unit_b_tdata(unit_b_tdata), .unit_b_tvalid(unit_b_tvalid), .unit_b_tready(unit_b_tready),
    .unit_r_tdata(unit_r_tdata), .unit_r_tvalid(unit_r_tvalid), .unit_r_tready(unit_r_tready)
  );

  fpu_axis_dispatch #(
    .DATA_W(DW), .NUM_UNITS(3), .UNIT_W(2), .TIMEOUT_CYCLES(16)
  ) u_dut3 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_unit(req_unit),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
    .busy(busy3),
    .unit_a_tdata(a_tdata3), .unit_a_tvalid(a_tvalid3), .unit_a_tready(3'b111),
    .unit_b_tdata(b_tdata3), .unit_b_tvalid(b_tvalid3), .unit_b_tready(3'b111),
    .unit_r_tdata({3{32'hDEAD_BEEF}}), .unit_r_tvalid(3'b111), .unit_r_tready(r_tready3)
  );

  // Core model: ready after a programmable number of cycles of valid; every
  // unit returns r_base + its index so mis-steering shows up in the data.
  int a_dly, b_dly, r_dly;
  int a_cnt, b_cnt, r_cnt;
  logic [DW-1:0] r_base;

  always @(posedge clk) begin
    a_cnt <= (|unit_a_tvalid) ? a_cnt + 1 : 0;
    b_cnt <= (|unit_b_tvalid) ? b_cnt + 1 : 0;
    r_cnt <= (|unit_r_tready) ? r_cnt + 1 : 0;
  end

  assign unit_a_tready = {NU{a_cnt >= a_dly}};
  assign unit_b_tready = {NU{b_cnt >= b_dly}};
  assign unit_r_tvalid = {NU{r_cnt >= r_dly}};

  always_comb begin
    unit_r_tdata = '0;
    for (int i = 0; i < NU; i++) unit_r_tdata[i*DW +: DW] = r_base + DW'(i);
  end

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_unit_sigs"}, 64'({unit_a_tvalid, unit_b_tvalid, unit_r_tready}), 64'd0);
  endtask

  // Issue one request on the main DUT, follow it to the response, compare
  // against the scoreboard. exp_lat <= 0 skips the latency check.
  task automatic run_req(input string tag, input logic [1:0] unit,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int ad, input int bd, input int rd,
                         input logic [DW-1:0] base, input bit exp_err,
                         input int exp_lat, input int hold,
                         output int a_hi, output int b_hi, output int r_first);
    int   lat;
    bit   stable_ok;
    logic [NU-1:0] other;
    exp_t e;
    a_dly = ad; b_dly = bd; r_dly = rd; r_base = base;
    e.err  = exp_err;
    e.data = exp_err ? '0 : base + DW'(unit);
    sb_q.push_back(e);
    @(negedge clk);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_unit = unit; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; a_hi = 0; b_hi = 0; r_first = 0; stable_ok = 1'b1; other = '0;
    do begin
      @(negedge clk);
      lat++;
      other |= (unit_a_tvalid | unit_b_tvalid | unit_r_tready) & ~(NU'(1) << unit);
      if (unit_a_tvalid[unit]) begin
        a_hi++;
        if (unit_a_tdata[int'(unit)*DW +: DW] !== a) stable_ok = 1'b0;
      end
      if (unit_b_tvalid[unit]) begin
        b_hi++;
        if (unit_b_tdata[int'(unit)*DW +: DW] !== b) stable_ok = 1'b0;
      end
      if (unit_r_tready[unit] && r_first == 0) r_first = lat;
    end while (!rsp_valid && lat < 100);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (exp_lat > 0) check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_tdata_stable"}, 64'(stable_ok), 64'd1);
    check_eq({tag, "_other_units"}, 64'(other), 64'd0);
    check_eq({tag, "_sigs_in_resp"}, 64'({unit_a_tvalid, unit_b_tvalid, unit_r_tready}), 64'd0);
    for (int h = 0; h < hold; h++) begin
      // A competing request while the response is pending must be ignored.
      req_valid = 1'b1; req_unit = 2'd0; req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check_eq({tag, "_hold_data"}, 64'(rsp_data), 64'(e.data));
      check_eq({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'(e.data));
      check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'(e.err));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_after_ready"}, 64'({req_ready, rsp_valid, busy}), 64'b100);
  endtask

  initial begin
    int ah, bh, rf, n;
    exp_t e;
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_unit = '0; req_a = '0; req_b = '0;
    req_valid3 = 1'b0; rsp_ready3 = 1'b0;
    a_dly = 0; b_dly = 0; r_dly = 0; r_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rstn = 1'b1;

    // Back-to-back ready core: 3-cycle latency.
    run_req("t1", 2'd0, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 32'h4040_0000, 1'b0, 3, 0,
            ah, bh, rf);
    check_eq("t1_a_hi", 64'(ah), 64'd1);
    check_eq("t1_b_hi", 64'(bh), 64'd1);
    check_eq("t1_r_first", 64'(rf), 64'd2);

    // Staggered operand handshakes.
    run_req("t2", 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 2, 5, 0, 32'h0000_1000, 1'b0, 8, 0,
            ah, bh, rf);
    check_eq("t2_a_hi", 64'(ah), 64'd3);
    check_eq("t2_b_hi", 64'(bh), 64'd6);
    check_eq("t2_r_first", 64'(rf), 64'd7);

    // Dead core: watchdog abort 16 cycles after SEND entry.
    run_req("t_timeout", 2'd2, 32'h1, 32'h2, 0, 0, 1000, 32'h5555_0000, 1'b1, 17, 0,
            ah, bh, rf);

    // Response back-pressure for 10 cycles.
    run_req("t_hold", 2'd1, 32'h4040_0000, 32'h3F80_0000, 0, 0, 2, 32'h40A0_0000, 1'b0, 5, 10,
            ah, bh, rf);

    for (int i = 0; i < 6; i++) begin
      run_req("t_rand", 2'($urandom_range(0, 3)), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
              $urandom, 1'b0, 0, $urandom_range(0, 2), ah, bh, rf);
    end

    // Illegal unit on the three-unit instance; stray r_tvalid is always high.
    @(negedge clk);
    check_eq("ill_idle_rsp_valid", 64'(rsp_valid3), 64'd0);
    e.err = 1'b1; e.data = '0;
    sb_q.push_back(e);
    req_valid3 = 1'b1; req_unit = 2'd3;
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    @(negedge clk);
    check_eq("ill_rsp_valid", 64'(rsp_valid3), 64'd1);
    check_eq("ill_unit_sigs", 64'({a_tvalid3, b_tvalid3, r_tready3}), 64'd0);
    e = sb_q.pop_front();
    check_eq("ill_rsp_err", 64'(rsp_err3), 64'(e.err));
    check_eq("ill_rsp_data", 64'(rsp_data3), 64'(e.data));
    rsp_ready3 = 1'b1;
    @(posedge clk);
    #1 rsp_ready3 = 1'b0;
    @(negedge clk);
    check_eq("ill_after_ready", 64'({req_ready3, rsp_valid3}), 64'b10);

    // Reset pulse while waiting for a result.
    r_dly = 5; a_dly = 0; b_dly = 0; r_base = 32'h7777_0000;
    @(negedge clk);
    req_valid = 1'b1; req_unit = 2'd1; req_a = 32'hAAAA_0001; req_b = 32'hBBBB_0002;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!unit_r_tready[1] && n < 20);
    check_eq("rst_reached_wait", 64'(unit_r_tready[1]), 64'd1);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_mid");
    rstn = 1'b1;
    r_dly = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_no_stray_rsp", 64'(rsp_valid), 64'd0);
    end
    run_req("t_post_rst", 2'd1, 32'h0BAD_F00D, 32'h0000_0003, 0, 0, 0, 32'h3000_0000, 1'b0, 3, 0,
            ah, bh, rf);

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
